// File: rtl/serial_pkg.sv
// Shared serial-link types for the frame transmitter and receiver.
// Line levels and the frame FSM state encoding.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/piso_frame_tx_if.sv
// Word handshake into the frame transmitter.
// Master offers a word, slave accepts when ready.
interface piso_frame_tx_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/bit_tick_counter.sv
// Per-bit tick counter: bit_end pulses on the last clock of each bit.
// Holds at zero while cleared.
module bit_tick_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic bit_end
);

    localparam int TW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    assign bit_end = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-to-serial frame transmitter: start, data, optional
// even parity and stop bit, each held CLKS_PER_BIT clocks.
module piso_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             reset,
    piso_frame_tx_if.slave   link,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             frame_done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_nxt;
    logic              nxt_bit;
    logic              par;
    logic [BW-1:0]     bitcnt;
    logic              idle;
    logic              bit_end;

    assign idle          = (state == IDLE);
    assign link.in_ready = idle;

    bit_tick_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .clear   (idle),
        .en      (!idle),
        .bit_end (bit_end)
    );

    // The bit leaving next sits at the shift-out end of the register.
    always_comb begin
        nxt_bit = sh[0];
        sh_nxt  = sh >> 1;
        if (LSB_FIRST == 0) begin
            nxt_bit = sh[DATA_W-1];
            sh_nxt  = sh << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sh         <= '0;
            par        <= 1'b0;
            bitcnt     <= '0;
            tx_out     <= LINE_IDLE;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (link.in_valid) begin
                        sh      <= link.in_data;
                        par     <= ^link.in_data;
                        state   <= START;
                        tx_out  <= LINE_START;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        tx_out <= nxt_bit;
                        sh     <= sh_nxt;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bitcnt == LAST_BIT) begin
                            bitcnt <= '0;
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                tx_out <= par;
                            end else begin
                                state  <= STOP;
                                tx_out <= LINE_IDLE;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            tx_out <= nxt_bit;
                            sh     <= sh_nxt;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        tx_out <= LINE_IDLE;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state      <= IDLE;
                        tx_busy    <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
